// File: rtl/jtdd_colmix.sv
// jtdd_colmix - colour mixer for the scroll/char/object layers.
//
// Resolves layer priority for each pixel. Looks the winning 9-bit index up
// in a CPU-writable palette made of two 512x8 byte RAMs (RG and B). Drives
// 4-bit-per-gun RGB with blanking aligned to the two-enable pipeline.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pxl_cen             pixel clock enable
//   cpu_cen             CPU bus enable, qualifies palette writes
//   cpu_AB[9:0]         [9] byte select (0 RG, 1 B), [8:0] palette entry
//   pal_cs, cpu_wrn     palette chip select, active-low write strobe
//   cpu_dout, pal_dout  CPU write data / CPU read data
//   char_pxl, obj_pxl   {pal[2:0], col[3:0]}
//   scr_pxl             {prio, pal[2:0], col[3:0]}
//   LHBL, LVBL          active-low blanking, aligned with the pixel inputs
//   red, green, blue    colour guns
//   LHBL_dly, LVBL_dly  blanking delayed to match the colour outputs
module jtdd_colmix #(
  parameter SIMFILE_RG = "pal_rg.bin",
  parameter SIMFILE_B  = "pal_b.bin"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       cpu_cen,
  input  logic [9:0] cpu_AB,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [7:0] scr_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // The init files are preloaded by the simulation environment only. The
  // empty block just keeps the names attached to this module.
  if ($bits(SIMFILE_RG) + $bits(SIMFILE_B) == 0) begin : g_no_init_files
  end

  logic [7:0] ram_rg [0:511];
  logic [7:0] ram_b  [0:511];
  logic [7:0] q_rg, q_b;
  logic [8:0] pxl_idx, nxt_idx;
  logic [8:0] ram_addr;
  logic       lhbl1, lvbl1, hit;
  logic       char_op, obj_op, scr_op;
  logic       cpu_we, we_rg, we_b;

  assign char_op = |char_pxl[3:0];
  assign obj_op  = |obj_pxl[3:0];
  assign scr_op  = |scr_pxl[3:0];

  // The scroll layer only beats objects when its priority bit is set and
  // its pixel is opaque. When everything is transparent the scroll index
  // (colour 0 of its palette) is shown as the backdrop.
  always_comb begin
    nxt_idx = {1'b1, scr_pxl};
    if (char_op)
      nxt_idx = {2'b00, char_pxl};
    else if (obj_op && !(scr_pxl[7] && scr_op))
      nxt_idx = {2'b01, obj_pxl};
  end

  // The CPU owns the shared address whenever it selects the palette. This
  // is what corrupts a concurrent pixel lookup.
  assign ram_addr = pal_cs ? cpu_AB[8:0] : pxl_idx;
  assign cpu_we   = cpu_cen & pal_cs & ~cpu_wrn;
  assign we_rg    = cpu_we & ~cpu_AB[9];
  assign we_b     = cpu_we &  cpu_AB[9];

  // Palette RAMs: registered read every clk, no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we_rg) ram_rg[ram_addr] <= cpu_dout;
    if (we_b)  ram_b[ram_addr]  <= cpu_dout;
    q_rg <= ram_rg[ram_addr];
    q_b  <= ram_b[ram_addr];
  end

  assign pal_dout = cpu_AB[9] ? q_b : q_rg;

  // Stage 1: latch the resolved index and blanking. hit is sampled on the
  // same edge that loads q, so it flags exactly the data stage 2 will use.
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_idx <= 9'd0;
      lhbl1   <= 1'b0;
      lvbl1   <= 1'b0;
      hit     <= 1'b0;
    end else begin
      hit <= pal_cs;
      if (pxl_cen) begin
        pxl_idx <= nxt_idx;
        lhbl1   <= LHBL;
        lvbl1   <= LVBL;
      end
    end
  end

  // Stage 2: blanking wins over everything. A collided lookup repeats the
  // last colour rather than showing whatever the CPU addressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_dly <= lhbl1;
      LVBL_dly <= lvbl1;
      if (!lhbl1 || !lvbl1) begin
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end else if (!hit) begin
        red   <= q_rg[3:0];
        green <= q_rg[7:4];
        blue  <= q_b[3:0];
      end
    end
  end

endmodule

// File: tb/tb_jtdd_colmix.sv
// tb_jtdd_colmix - directed, table-driven bench for jtdd_colmix.
//
// Each pixel lasts 4 clk with pxl_cen high on the first. The outputs
// checked after a pixel call therefore belong to the previous pixel.
module tb_jtdd_colmix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       cpu_cen = 1'b0;
  logic [9:0] cpu_AB = '0;
  logic       pal_cs = 1'b0;
  logic       cpu_wrn = 1'b1;
  logic [7:0] cpu_dout = '0;
  logic [7:0] pal_dout;
  logic [6:0] char_pxl = '0;
  logic [6:0] obj_pxl = '0;
  logic [7:0] scr_pxl = '0;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rg_m [0:511];
  logic [7:0] b_m  [0:511];

  typedef struct {
    logic [6:0] chr;
    logic [6:0] obj;
    logic [7:0] scr;
    logic       hb;
    logic       vb;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;

  vec_t vecs [10];

  jtdd_colmix dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .cpu_cen  (cpu_cen),
    .cpu_AB   (cpu_AB),
    .pal_cs   (pal_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .char_pxl (char_pxl),
    .obj_pxl  (obj_pxl),
    .scr_pxl  (scr_pxl),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  // All tasks are entered and left on a falling edge.
  task automatic cpuWrite(input logic [9:0] addr, input logic [7:0] data, input logic cen);
    pal_cs   = 1'b1;
    cpu_wrn  = 1'b0;
    cpu_cen  = cen;
    cpu_AB   = addr;
    cpu_dout = data;
    @(negedge clk);
    pal_cs  = 1'b0;
    cpu_wrn = 1'b1;
    cpu_cen = 1'b0;
  endtask

  task automatic cpuRead(input logic [9:0] addr, output logic [7:0] data);
    pal_cs  = 1'b1;
    cpu_wrn = 1'b1;
    cpu_AB  = addr;
    @(negedge clk);
    data   = pal_dout;
    pal_cs = 1'b0;
  endtask

  // One pixel. With collide set, a CPU write lands on the last clk of the
  // pixel, which is the read that feeds stage 2 of this pixel.
  task automatic applyStimulus(input logic [6:0] chr, input logic [6:0] obj,
                               input logic [7:0] scr, input logic hb, input logic vb,
                               input logic collide, input logic [9:0] waddr,
                               input logic [7:0] wdata);
    char_pxl = chr;
    obj_pxl  = obj;
    scr_pxl  = scr;
    LHBL     = hb;
    LVBL     = vb;
    pxl_cen  = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (collide) begin
      pal_cs   = 1'b1;
      cpu_wrn  = 1'b0;
      cpu_cen  = 1'b1;
      cpu_AB   = waddr;
      cpu_dout = wdata;
    end
    @(negedge clk);
    pal_cs  = 1'b0;
    cpu_wrn = 1'b1;
    cpu_cen = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] er, input logic [3:0] eg,
                             input logic [3:0] eb, input logic ehb, input logic evb);
    vectors++;
    if (red !== er || green !== eg || blue !== eb || LHBL_dly !== ehb || LVBL_dly !== evb) begin
      miscompares++;
      $display("[TB] FAIL %s: got rgb=%h%h%h hb=%b vb=%b, expected rgb=%h%h%h hb=%b vb=%b",
               name, red, green, blue, LHBL_dly, LVBL_dly, er, eg, eb, ehb, evb);
    end
  endtask

  task automatic checkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       hb_pat [9];

    // Entries are loaded with RG = i[7:0], B = i[7:0] ^ 0x5A. Expected guns
    // below are worked out by hand from that rule.
    vecs[0] = '{7'h12, 7'h34, 8'h05, 1'b1, 1'b1, 4'h2, 4'h1, 4'h8}; // char -> 012
    vecs[1] = '{7'h00, 7'h34, 8'h85, 1'b1, 1'b1, 4'h5, 4'h8, 4'hF}; // scr prio -> 185
    vecs[2] = '{7'h00, 7'h34, 8'h05, 1'b1, 1'b1, 4'h4, 4'hB, 4'hE}; // obj -> 0B4
    vecs[3] = '{7'h70, 7'h50, 8'h80, 1'b1, 1'b1, 4'h0, 4'h8, 4'hA}; // all clear -> 180
    vecs[4] = '{7'h0F, 7'h34, 8'h85, 1'b1, 1'b1, 4'hF, 4'h0, 4'h5}; // char -> 00F
    vecs[5] = '{7'h00, 7'h7F, 8'hF0, 1'b1, 1'b1, 4'hF, 4'hF, 4'h5}; // prio but scr clear -> 0FF
    vecs[6] = '{7'h21, 7'h34, 8'h85, 1'b1, 1'b1, 4'h1, 4'h2, 4'hB}; // char over prio -> 021
    vecs[7] = '{7'h12, 7'h34, 8'h05, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0}; // H blank
    vecs[8] = '{7'h12, 7'h34, 8'h05, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0}; // V blank
    vecs[9] = '{7'h00, 7'h30, 8'h4C, 1'b1, 1'b1, 4'hC, 4'h4, 4'h6}; // scr no prio -> 14C

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_state", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Byte write and readback on both RAMs
    cpuWrite(10'h105, 8'hA5, 1'b1);
    cpuWrite(10'h305, 8'h03, 1'b1);
    cpuRead(10'h105, rd);
    checkByte("rd_rg_105", rd, 8'hA5);
    cpuRead(10'h305, rd);
    checkByte("rd_b_105", rd, 8'h03);

    // Full palette load
    for (int i = 0; i < 512; i++) begin
      rg_m[i] = i[7:0];
      b_m[i]  = i[7:0] ^ 8'h5A;
      cpuWrite({1'b0, i[8:0]}, rg_m[i], 1'b1);
      cpuWrite({1'b1, i[8:0]}, b_m[i], 1'b1);
    end
    cpuRead(10'h2F5, rd);
    checkByte("rd_b_upper_nibble", rd, b_m[9'h0F5]);

    // A write without cpu_cen must leave the entry untouched
    cpuWrite(10'h0AA, 8'hEE, 1'b0);
    cpuRead(10'h0AA, rd);
    checkByte("write_no_cen", rd, rg_m[9'h0AA]);

    // Priority / lookup table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].chr, vecs[i].obj, vecs[i].scr, vecs[i].hb, vecs[i].vb,
                    1'b0, 10'h0, 8'h0);
      if (i > 0)
        checkOutput($sformatf("vec%0d", i - 1), vecs[i-1].r, vecs[i-1].g, vecs[i-1].b,
                    vecs[i-1].hb, vecs[i-1].vb);
    end
    applyStimulus(7'h12, 7'h34, 8'h05, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("vec9", vecs[9].r, vecs[9].g, vecs[9].b, vecs[9].hb, vecs[9].vb);

    // LHBL low for three pixels on a steady colour (entry 012)
    hb_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int n = 0; n < 9; n++) begin
      applyStimulus(7'h12, 7'h34, 8'h05, hb_pat[n], 1'b1, 1'b0, 10'h0, 8'h0);
      if (n > 0) begin
        if (hb_pat[n-1])
          checkOutput($sformatf("hblank_px%0d", n - 1), 4'h2, 4'h1, 4'h8, 1'b1, 1'b1);
        else
          checkOutput($sformatf("hblank_px%0d", n - 1), 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      end
    end

    // Collision: C1 = entry 00F (F,0,5), C2 = entry 021 (1,2,B)
    applyStimulus(7'h0F, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    applyStimulus(7'h0F, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("collide_c1", 4'hF, 4'h0, 4'h5, 1'b1, 1'b1);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b1, 10'h1AA, 8'h3C);
    rg_m[9'h1AA] = 8'h3C;
    checkOutput("collide_prev", 4'hF, 4'h0, 4'h5, 1'b1, 1'b1);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("collide_hold", 4'hF, 4'h0, 4'h5, 1'b1, 1'b1);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("collide_next", 4'h1, 4'h2, 4'hB, 1'b1, 1'b1);
    cpuRead(10'h1AA, rd);
    checkByte("collide_readback", rd, rg_m[9'h1AA]);

    // Collision inside blanking still outputs black
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 10'h3AA, 8'h7E);
    b_m[9'h1AA] = 8'h7E;
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("collide_blank", 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("collide_blank_next", 4'h1, 4'h2, 4'hB, 1'b1, 1'b1);
    cpuRead(10'h3AA, rd);
    checkByte("collide_blank_readback", rd, b_m[9'h1AA]);

    // One-clk reset mid-line
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("pre_reset", 4'h1, 4'h2, 4'hB, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midline_reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("refill_1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(7'h21, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 10'h0, 8'h0);
    checkOutput("refill_2", 4'h1, 4'h2, 4'hB, 1'b1, 1'b1);
    cpuRead(10'h1AA, rd);
    checkByte("post_reset_rg", rd, rg_m[9'h1AA]);
    cpuRead(10'h305, rd);
    checkByte("post_reset_b", rd, b_m[9'h105]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
